// File: rtl/bcd_alu_ctrl.sv
// Digit-serial sign-magnitude BCD add/subtract sequencer: compares magnitudes MSB first,
// then adds or subtracts one digit per cycle LSB first and returns a normalised signed result.
module bcd_alu_ctrl #(
    parameter int DIGIT_NUM = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [DIGIT_NUM*4-1:0] operand0,
    input  logic                   operand0_sign,
    input  logic [DIGIT_NUM*4-1:0] operand1,
    input  logic                   operand1_sign,
    output logic                   busy,
    output logic                   done,
    output logic [DIGIT_NUM*4-1:0] result,
    output logic                   result_sign,
    output logic                   overflow,
    output logic                   error
);

    localparam int W  = DIGIT_NUM * 4;
    localparam int CW = $clog2(DIGIT_NUM);
    localparam logic [CW-1:0] LAST = CW'(DIGIT_NUM - 1);
    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {IDLE, CMP, ADD, DONE} state_t;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Returns {carry_out, digit}; any raw sum above 9 lands in 16..25 after +6.
    function automatic logic [4:0] bcd_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        if (s > 5'd9) s = s + 5'd6;
        return s;
    endfunction

    // Returns {borrow_out, digit}.
    function automatic logic [4:0] bcd_sub(input logic [3:0] x, input logic [3:0] y,
                                           input logic bin);
        logic signed [5:0] d;
        logic              neg;
        d   = $signed({2'b00, x}) - $signed({2'b00, y}) - $signed({5'b00000, bin});
        neg = (d < 6'sd0);
        if (neg) d = d + 6'sd10;
        return {neg, d[3:0]};
    endfunction

    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          gt_q, gt_d;
    logic          lt_q, lt_d;
    logic          sub_q, sub_d;
    logic          sign_q, sign_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  result_q, result_d;
    logic          result_sign_q, result_sign_d;
    logic          overflow_q, overflow_d;
    logic          error_q, error_d;

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [2:0]    op_q, op_d;
    logic          s0_q, s0_d;
    logic          s1_q, s1_d;

    logic [3:0]    a_dig, b_dig;
    logic [4:0]    dig;
    logic          eff_s1, invalid, accept;

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        cnt_d         = cnt_q;
        carry_d       = carry_q;
        gt_d          = gt_q;
        lt_d          = lt_q;
        sub_d         = sub_q;
        sign_d        = sign_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_d      = result_q;
        result_sign_d = result_sign_q;
        overflow_d    = overflow_q;
        error_d       = error_q;
        a_d           = a_q;
        b_d           = b_q;
        acc_d         = acc_q;
        op_d          = op_q;
        s0_d          = s0_q;
        s1_d          = s1_q;

        a_dig   = a_q[4*int'(cnt_q) +: 4];
        b_dig   = b_q[4*int'(cnt_q) +: 4];
        dig     = sub_q ? bcd_sub(a_dig, b_dig, carry_q) : bcd_add(a_dig, b_dig, carry_q);
        eff_s1  = s1_q ^ (op_q == OP_SUB);
        invalid = ((op_q != OP_SUM) && (op_q != OP_SUB)) || has_bad_digit(a_q)
                  || has_bad_digit(b_q);
        accept  = start && !pend_q && ((state_q == IDLE) || (state_q == DONE));

        // Operands are captured here; validation happens on the following edge.
        if (accept) begin
            pend_d = 1'b1;
            a_d    = operand0;
            b_d    = operand1;
            op_d   = op;
            s0_d   = operand0_sign;
            s1_d   = operand1_sign;
        end

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (invalid) begin
                        state_d       = DONE;
                        done_d        = 1'b1;
                        error_d       = 1'b1;
                        result_d      = '0;
                        result_sign_d = 1'b0;
                        overflow_d    = 1'b0;
                    end else if (s0_q == eff_s1) begin
                        state_d = ADD;
                        busy_d  = 1'b1;
                        sub_d   = 1'b0;
                        sign_d  = s0_q;
                        cnt_d   = '0;
                        carry_d = 1'b0;
                    end else begin
                        state_d = CMP;
                        busy_d  = 1'b1;
                        cnt_d   = LAST;
                        gt_d    = 1'b0;
                        lt_d    = 1'b0;
                    end
                end
            end
            CMP: begin
                if (!gt_q && !lt_q) begin
                    gt_d = (a_dig > b_dig);
                    lt_d = (a_dig < b_dig);
                end
                cnt_d = cnt_q - CW'(1);
                // Put the larger magnitude in a so the subtractor never ends with a borrow.
                if (cnt_q == '0) begin
                    state_d = ADD;
                    sub_d   = 1'b1;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    if (lt_d) begin
                        a_d    = b_q;
                        b_d    = a_q;
                        sign_d = eff_s1;
                    end else begin
                        sign_d = s0_q;
                    end
                end
            end
            ADD: begin
                acc_d   = {dig[3:0], acc_q[W-1:4]};
                carry_d = dig[4];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d       = DONE;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    result_d      = acc_d;
                    overflow_d    = !sub_q && dig[4];
                    result_sign_d = sign_q && (acc_d != '0);
                    error_d       = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pend_q        <= 1'b0;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            gt_q          <= 1'b0;
            lt_q          <= 1'b0;
            sub_q         <= 1'b0;
            sign_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            result_sign_q <= 1'b0;
            overflow_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            cnt_q         <= cnt_d;
            carry_q       <= carry_d;
            gt_q          <= gt_d;
            lt_q          <= lt_d;
            sub_q         <= sub_d;
            sign_q        <= sign_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_q      <= result_d;
            result_sign_q <= result_sign_d;
            overflow_q    <= overflow_d;
            error_q       <= error_d;
        end
    end

    always_ff @(posedge clock) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        op_q  <= op_d;
        s0_q  <= s0_d;
        s1_q  <= s1_d;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign result_sign = result_sign_q;
    assign overflow    = overflow_q;
    assign error       = error_q;

endmodule

// File: tb/tb_bcd_alu_ctrl.sv
// Self-checking bench for bcd_alu_ctrl: integer-arithmetic reference model, per-cycle compare
// process, directed cases and randomized operations.
module tb_bcd_alu_ctrl;

    localparam int N = 8;
    localparam int W = N * 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] operand0 = '0;
    logic [W-1:0] operand1 = '0;
    logic         operand0_sign = 1'b0;
    logic         operand1_sign = 1'b0;
    logic         busy, done, result_sign, overflow, error;
    logic [W-1:0] result;

    bcd_alu_ctrl #(.DIGIT_NUM(N)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand0(operand0), .operand0_sign(operand0_sign),
        .operand1(operand1), .operand1_sign(operand1_sign),
        .busy(busy), .done(done), .result(result), .result_sign(result_sign),
        .overflow(overflow), .error(error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: pending (p_*) outcome of the running op and held (h_*) visible outputs.
    bit           active = 1'b0;
    int           start_edge = 0;
    int           done_edge = 0;
    logic [W-1:0] p_res = '0, h_res = '0;
    logic         p_sign = 1'b0, p_ovf = 1'b0, p_err = 1'b0;
    logic         h_sign = 1'b0, h_ovf = 1'b0, h_err = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, want %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint to_int(input logic [W-1:0] v, output bit bad);
        longint r;
        r   = 0;
        bad = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
            r = r * 10 + longint'(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint m);
        logic [W-1:0] r;
        longint       t;
        r = '0;
        t = m;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic as,
                                  input logic [W-1:0] b, input logic bs,
                                  output logic [W-1:0] r, output logic rs, output logic ov,
                                  output logic er, output int lat);
        longint ma, mb, va, vb, s, mag, lim;
        bit     ba, bb, neg_b;
        ma  = to_int(a, ba);
        mb  = to_int(b, bb);
        lim = 1;
        for (int i = 0; i < N; i++) lim = lim * 10;
        er = ba || bb || (o > 3'd1);
        if (er) begin
            r = '0; rs = 1'b0; ov = 1'b0; lat = 1;
            return;
        end
        neg_b = bs ^ (o == 3'd1);
        va    = as ? -ma : ma;
        vb    = neg_b ? -mb : mb;
        s     = va + vb;
        mag   = (s < 0) ? -s : s;
        ov    = (mag >= lim);
        mag   = mag % lim;
        r     = to_bcd(mag);
        rs    = (s < 0) && (mag != 0);
        lat   = (as == neg_b) ? N + 1 : 2 * N + 1;
    endfunction

    // Compare process: every cycle, 1 time unit after the rising edge.
    always @(posedge clock) begin
        #1;
        if (active && cyc == done_edge) begin
            h_res  = p_res;
            h_sign = p_sign;
            h_ovf  = p_ovf;
            h_err  = p_err;
        end
        chk1("done", done, active && (cyc == done_edge));
        chk1("busy", busy, active && !p_err && (cyc > start_edge) && (cyc < done_edge));
        chkw("result", result, h_res);
        chk1("result_sign", result_sign, h_sign);
        chk1("overflow", overflow, h_ovf);
        chk1("error", error, h_err);
    end

    // Called at a falling edge; returns one falling edge later with inputs scrambled.
    task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic as,
                          input logic [W-1:0] b, input logic bs);
        int lat;
        op = o; operand0 = a; operand0_sign = as; operand1 = b; operand1_sign = bs;
        start = 1'b1;
        model(o, a, as, b, bs, p_res, p_sign, p_ovf, p_err, lat);
        start_edge = cyc + 1;
        done_edge  = start_edge + lat;
        active     = 1'b1;
        @(negedge clock);
        start         = 1'b0;
        op            = 3'($urandom);
        operand0      = W'($urandom);
        operand1      = W'($urandom);
        operand0_sign = 1'($urandom);
        operand1_sign = 1'($urandom);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (cyc < done_edge && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk1("done_within_bound", cyc >= done_edge, 1'b1);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] r, input logic rs,
                              input logic ov, input logic er);
        chkw({name, "_result"}, result, r);
        chk1({name, "_sign"}, result_sign, rs);
        chk1({name, "_overflow"}, overflow, ov);
        chk1({name, "_error"}, error, er);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        int           k;
        r = '0;
        k = $urandom_range(1, N);
        for (int i = 0; i < k; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] mr, a, b;
        logic         mrs, mov, mer, as, bs;
        logic [2:0]   o;
        int           mlat, sel;

        repeat (3) @(negedge clock);
        expect_out("reset", '0, 1'b0, 1'b0, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        model(3'b000, 32'h00000123, 1'b0, 32'h00000456, 1'b0, mr, mrs, mov, mer, mlat);
        chkw("model_sum", mr, 32'h00000579);
        chkw("model_sum_lat", mlat, 9);
        model(3'b001, 32'h00000100, 1'b0, 32'h00000250, 1'b0, mr, mrs, mov, mer, mlat);
        chkw("model_sub", mr, 32'h00000150);
        chk1("model_sub_sign", mrs, 1'b1);
        chkw("model_sub_lat", mlat, 17);
        model(3'b010, 32'h1, 1'b0, 32'h1, 1'b0, mr, mrs, mov, mer, mlat);
        chkw("model_err_lat", mlat, 1);

        launch(3'b000, 32'h00000123, 1'b0, 32'h00000456, 1'b0);
        wait_done();
        expect_out("sum_579", 32'h00000579, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        launch(3'b001, 32'h00000100, 1'b0, 32'h00000250, 1'b0);
        wait_done();
        expect_out("sub_150", 32'h00000150, 1'b1, 1'b0, 1'b0);

        // Back-to-back starts issued in the done cycle.
        launch(3'b000, 32'h99999999, 1'b0, 32'h00000001, 1'b0);
        wait_done();
        expect_out("wrap", 32'h00000000, 1'b0, 1'b1, 1'b0);
        launch(3'b000, 32'h00000999, 1'b0, 32'h00000001, 1'b0);
        wait_done();
        expect_out("carry_chain", 32'h00001000, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        launch(3'b000, 32'h00000042, 1'b1, 32'h00000042, 1'b0);
        wait_done();
        expect_out("neg_zero_sum", 32'h0, 1'b0, 1'b0, 1'b0);
        launch(3'b001, 32'h00000007, 1'b0, 32'h00000007, 1'b0);
        wait_done();
        expect_out("neg_zero_sub", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        launch(3'b010, 32'h00000011, 1'b0, 32'h00000022, 1'b0);
        wait_done();
        expect_out("bad_op", 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        launch(3'b000, 32'h0000000A, 1'b0, 32'h00000001, 1'b0);
        wait_done();
        expect_out("bad_digit", 32'h0, 1'b0, 1'b0, 1'b1);
        launch(3'b000, 32'h00000002, 1'b1, 32'h00000003, 1'b1);
        wait_done();
        expect_out("err_clear", 32'h00000005, 1'b1, 1'b0, 1'b0);
        @(negedge clock);

        // Reset four cycles into an ADD.
        launch(3'b000, 32'h12345678, 1'b0, 32'h11111111, 1'b0);
        repeat (4) @(negedge clock);
        reset  = 1'b1;
        active = 1'b0;
        h_res  = '0; h_sign = 1'b0; h_ovf = 1'b0; h_err = 1'b0;
        #1;
        expect_out("midop_reset", '0, 1'b0, 1'b0, 1'b0);
        chk1("midop_reset_busy", busy, 1'b0);
        chk1("midop_reset_done", done, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        launch(3'b000, 32'h00000005, 1'b0, 32'h00000003, 1'b0);
        wait_done();
        expect_out("after_reset", 32'h00000008, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        // A start while busy must be dropped.
        launch(3'b000, 32'h00000011, 1'b0, 32'h00000022, 1'b0);
        repeat (3) @(negedge clock);
        op = 3'b001; operand0 = 32'h00000999; operand1 = 32'h00000555; operand0_sign = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        expect_out("ignored_start", 32'h00000033, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 15);
            o   = (sel < 7) ? 3'b000 : (sel < 14) ? 3'b001 : 3'($urandom_range(2, 7));
            a   = rand_bcd();
            b   = rand_bcd();
            sel = $urandom_range(0, 9);
            if (sel == 0) b = a;
            if (sel == 1) a = 32'h99999999;
            if (sel == 2) a[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
            as = 1'($urandom);
            bs = 1'($urandom);
            launch(o, a, as, b, bs);
            wait_done();
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
